// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : handshaked MEM-stage data memory with registered read data,
//                 range checking and optional two-beat misaligned accesses.
// Revision      : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int MISALIGN_EN    = 1,
    parameter int RD_ZERO_ON_ERR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    state_t            state_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    // Context of an in-flight split access, captured at accept.
    logic              we_q;
    logic [2:0]        func_q;
    logic [1:0]        off_q;
    logic [IDX_W-1:0]  idx1_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_data_q;
    logic [3:0]        hi_be_q;

    logic [1:0]        w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [3:0]        w_size_mask;
    logic [7:0]        w_be_wide;
    logic [63:0]       w_wdata_wide;
    logic              w_misaligned;
    logic              w_oor;
    logic              w_err;
    logic              w_accept;
    logic [31:0]       w_rd_lo;
    logic [31:0]       w_rd_hi;
    logic [31:0]       w_lo_raw;
    logic [31:0]       w_split_raw;
    logic              w_en;
    logic [IDX_W-1:0]  w_addr;
    logic [31:0]       w_data;
    logic [3:0]        w_be;
    logic [31:0]       w_mask;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] func);
        logic [31:0] res;
        case (func)
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b101:  res = {16'h0, raw[15:0]};
            3'b010:  res = {{24{raw[7]}}, raw[7:0]};
            3'b110:  res = {24'h0, raw[7:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign w_off = req_addr[1:0];
    assign w_idx = req_addr[ADDR_W-1:2];

    always_comb begin
        case (req_func)
            3'b001, 3'b101: w_size_mask = 4'b0011;
            3'b010, 3'b110: w_size_mask = 4'b0001;
            default:        w_size_mask = 4'b1111;
        endcase
    end

    // Lanes [3:0] belong to word idx, lanes [7:4] spill into word idx+1.
    assign w_be_wide    = {4'b0000, w_size_mask} << w_off;
    assign w_wdata_wide = {32'h0, req_wdata} << {w_off, 3'b000};
    assign w_misaligned = |w_be_wide[7:4];

    if (ADDR_W < 32) begin : g_oor
        assign w_oor = |req_addr[31:ADDR_W];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end

    assign w_err = w_oor | (w_misaligned & ((MISALIGN_EN == 0) | (&w_idx)));

    assign req_ready = (state_q == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    assign w_rd_lo     = mem_q[w_idx];
    assign w_rd_hi     = mem_q[idx1_q];
    assign w_lo_raw    = w_rd_lo >> {w_off, 3'b000};
    assign w_split_raw = 32'({w_rd_hi, lo_q} >> {off_q, 3'b000});

    // Only one beat touches the array per edge: beat 1 in SPLIT, else the accepted request.
    always_comb begin
        if (state_q == SPLIT) begin
            w_en   = we_q & ~rst;
            w_addr = idx1_q;
            w_data = hi_data_q;
            w_be   = hi_be_q;
        end else begin
            w_en   = w_accept & req_we & ~w_err;
            w_addr = w_idx;
            w_data = w_wdata_wide[31:0];
            w_be   = w_be_wide[3:0];
        end
    end

    assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_q[w_addr] <= (mem_q[w_addr] & ~w_mask) | (w_data & w_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            we_q      <= req_we;
            func_q    <= req_func;
            off_q     <= w_off;
            idx1_q    <= w_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            lo_q      <= w_rd_lo;
            hi_data_q <= w_wdata_wide[63:32];
            hi_be_q   <= w_be_wide[7:4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            if (RD_ZERO_ON_ERR != 0) begin
                                rsp_rdata_q <= 32'h0;
                            end
                        end else if (w_misaligned) begin
                            state_q <= SPLIT;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= req_we ? 32'h0 : extend(w_lo_raw, req_func);
                        end
                    end
                end
                SPLIT: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? 32'h0 : extend(w_split_raw, func_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_data_mem_ctrl : byte-level reference model checked every cycle, plus
//                    directed transactions with hand-computed results.
// Revision         : 1.0
// ============================================================================
module tb_data_mem_ctrl;
    localparam logic [2:0] F_WORD = 3'b000, F_HALF = 3'b001, F_BYTE = 3'b010;
    localparam logic [2:0] F_HALFU = 3'b101, F_BYTEU = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_func = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        na_valid = 1'b0, na_we = 1'b0;
    logic [2:0]  na_func = 3'b0;
    logic [31:0] na_addr = 32'h0, na_wdata = 32'h0;
    logic        na_ready, na_rsp_valid, na_err;
    logic [31:0] na_rdata;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(10), .MISALIGN_EN(1), .RD_ZERO_ON_ERR(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    data_mem_ctrl #(.ADDR_W(10), .MISALIGN_EN(0), .RD_ZERO_ON_ERR(1)) dut_na (
        .clk(clk), .rst(rst), .req_valid(na_valid), .req_ready(na_ready),
        .req_we(na_we), .req_func(na_func), .req_addr(na_addr), .req_wdata(na_wdata),
        .rsp_valid(na_rsp_valid), .rsp_rdata(na_rdata), .rsp_err(na_err));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // Reference model: byte memory, response queue keyed by visible cycle.
    typedef struct { int due; logic [31:0] d; logic e; } rsp_t;
    rsp_t        rq[$];
    logic [7:0]  mm [0:1023] = '{default: 8'h0};
    int          cyc = 0;
    bit          m_busy = 0, m_valid = 0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err = 1'b0;
    int          p_n = 0;
    int          p_a [3];
    logic [7:0]  p_d [3];

    function automatic int fsize(input logic [2:0] f);
        case (f)
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 1;
            default:        return 4;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit acc, mis;
        int sz, off, a;
        logic [31:0] v;
        rsp_t r;
        acc = req_valid && !rst && !m_busy;
        cyc++;
        m_valid = 0;
        if (rst) begin
            rq.delete();
            m_busy = 0; p_n = 0; m_rdata = 32'h0; m_err = 1'b0;
        end else begin
            if (m_busy) begin
                for (int k = 0; k < p_n; k++) mm[p_a[k]] = p_d[k];
                p_n = 0; m_busy = 0;
            end
            if (acc) begin
                sz  = fsize(req_func);
                a   = int'(req_addr[9:0]);
                off = a % 4;
                mis = (off + sz > 4);
                v   = 32'h0;
                if (req_addr >= 32'd1024 || (mis && a / 4 == 255)) begin
                    r.due = cyc; r.d = 32'h0; r.e = 1'b1;
                end else begin
                    for (int k = 0; k < sz; k++) begin
                        if (req_we) begin
                            if ((a + k) / 4 == a / 4) mm[a + k] = req_wdata[8*k +: 8];
                            else begin p_a[p_n] = a + k; p_d[p_n] = req_wdata[8*k +: 8]; p_n++; end
                        end else v[8*k +: 8] = mm[a + k];
                    end
                    if (!req_we && req_func == F_HALF && v[15]) v[31:16] = 16'hFFFF;
                    if (!req_we && req_func == F_BYTE && v[7])  v[31:8]  = 24'hFFFFFF;
                    r.due = mis ? cyc + 1 : cyc; r.d = v; r.e = 1'b0;
                    if (mis) m_busy = 1;
                end
                rq.push_back(r);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m_valid = 1; m_rdata = rq[0].d; m_err = rq[0].e;
                void'(rq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("req_ready", 32'(req_ready), 32'(!rst && !m_busy));
            chk("rsp_err",   32'(rsp_err),   32'(m_err));
            chk("rsp_rdata", rsp_rdata, m_rdata);
        end
    end

    int          nrsp = 0;
    logic [31:0] last_rd = 32'h0;
    always @(negedge clk) begin
        if (rsp_valid) begin nrsp++; last_rd = rsp_rdata; end
    end

    task automatic txn(input bit na, input bit we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
        bit acc, got;
        acc = 0; got = 0; rd = 32'hxxxxxxxx; e = 1'bx; lat = -1;
        if (na) begin na_valid = 1; na_we = we; na_func = f; na_addr = a; na_wdata = wd; end
        else    begin req_valid = 1; req_we = we; req_func = f; req_addr = a; req_wdata = wd; end
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk); acc = na ? na_ready : req_ready;
            @(posedge clk);
        end
        #1; req_valid = 0; na_valid = 0;
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout: got no req_ready, expected acceptance within 20 cycles");
        end else begin
            for (int i = 1; i <= 6 && !got; i++) begin
                @(negedge clk);
                if (na ? na_rsp_valid : rsp_valid) begin
                    got = 1; lat = i;
                    rd = na ? na_rdata : rsp_rdata;
                    e  = na ? na_err : rsp_err;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic t_chk(input string nm, input bit na, input bit we, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] xrd, input logic xe, input int xlat);
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(na, we, f, a, wd, rd, e, lat);
        chk({nm, ".rdata"}, rd, xrd);
        chk({nm, ".err"}, 32'(e), 32'(xe));
        chk({nm, ".lat"}, lat, xlat);
    endtask

    task automatic stream(input bit we, input logic [31:0] base, input int n, input logic [31:0] dbase);
        for (int i = 0; i < n; i++) begin
            req_valid = 1; req_we = we; req_func = F_WORD;
            req_addr = base + 32'(4 * i); req_wdata = dbase + 32'(i);
            @(posedge clk); #1;
        end
        req_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish within 100000 ns");
        $fatal(1);
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'h1);
        @(posedge clk); #1;

        // Store then load the same word on consecutive cycles.
        req_valid = 1; req_we = 1; req_func = F_WORD; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_we = 0; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (2) @(posedge clk); #1;
        chk("st_ld_0x10", last_rd, 32'hDEADBEEF);

        t_chk("st_b13",   0, 1, F_BYTE,  32'h13, 32'h00000080, 32'h00000000, 0, 1);
        t_chk("ld_b13",   0, 0, F_BYTE,  32'h13, 32'h0,        32'hFFFFFF80, 0, 1);
        t_chk("ld_bu13",  0, 0, F_BYTEU, 32'h13, 32'h0,        32'h00000080, 0, 1);
        t_chk("ld_w10",   0, 0, F_WORD,  32'h10, 32'h0,        32'h80ADBEEF, 0, 1);
        t_chk("ld_h12",   0, 0, F_HALF,  32'h12, 32'h0,        32'hFFFF80AD, 0, 1);
        t_chk("ld_hu12",  0, 0, F_HALFU, 32'h12, 32'h0,        32'h000080AD, 0, 1);
        t_chk("ld_f7_10", 0, 0, 3'b111,  32'h10, 32'h0,        32'h80ADBEEF, 0, 1);

        t_chk("st_w22",   0, 1, F_WORD,  32'h22, 32'h11223344, 32'h00000000, 0, 2);
        t_chk("ld_w20",   0, 0, F_WORD,  32'h20, 32'h0,        32'h33440000, 0, 1);
        t_chk("ld_w24",   0, 0, F_WORD,  32'h24, 32'h0,        32'h00001122, 0, 1);
        t_chk("ld_h23",   0, 0, F_HALF,  32'h23, 32'h0,        32'h00002233, 0, 2);
        t_chk("ld_h21",   0, 0, F_HALF,  32'h21, 32'h0,        32'h00004400, 0, 1);
        t_chk("st_h27",   0, 1, F_HALF,  32'h27, 32'hFFFF9876, 32'h00000000, 0, 2);
        t_chk("ld_h27",   0, 0, F_HALF,  32'h27, 32'h0,        32'hFFFF9876, 0, 2);
        t_chk("ld_hu27",  0, 0, F_HALFU, 32'h27, 32'h0,        32'h00009876, 0, 2);

        t_chk("ld_oor",   0, 0, F_WORD,  32'h400, 32'h0,        32'h0, 1, 1);
        t_chk("st_oor",   0, 1, F_WORD,  32'h404, 32'hFFFFFFFF, 32'h0, 1, 1);
        t_chk("ld_w04",   0, 0, F_WORD,  32'h004, 32'h0,        32'h0, 0, 1);
        t_chk("ld_wrap",  0, 0, F_WORD,  32'h3FE, 32'h0,        32'h0, 1, 1);
        t_chk("st_wrap",  0, 1, F_HALF,  32'h3FF, 32'h0000BEEF, 32'h0, 1, 1);
        t_chk("ld_b3ff",  0, 0, F_BYTEU, 32'h3FF, 32'h0,        32'h0, 0, 1);
        t_chk("ld_w000",  0, 0, F_WORD,  32'h000, 32'h0,        32'h0, 0, 1);
        t_chk("st_w3fc",  0, 1, F_WORD,  32'h3FC, 32'h01020304, 32'h0, 0, 1);
        t_chk("ld_hu3fe", 0, 0, F_HALFU, 32'h3FE, 32'h0,        32'h00000102, 0, 1);

        t_chk("na_st_w01", 1, 1, F_WORD, 32'h01, 32'h12345678, 32'h0,        1, 1);
        t_chk("na_ld_w00", 1, 0, F_WORD, 32'h00, 32'h0,        32'h0,        0, 1);
        t_chk("na_ld_w04", 1, 0, F_WORD, 32'h04, 32'h0,        32'h0,        0, 1);
        t_chk("na_st_w08", 1, 1, F_WORD, 32'h08, 32'hCAFEF00D, 32'h0,        0, 1);
        t_chk("na_ld_w08", 1, 0, F_WORD, 32'h08, 32'h0,        32'hCAFEF00D, 0, 1);
        t_chk("na_ld_h09", 1, 0, F_HALF, 32'h09, 32'h0,        32'hFFFFFEF0, 0, 1);
        t_chk("na_ld_h0b", 1, 0, F_HALF, 32'h0B, 32'h0,        32'h0,        1, 1);

        // Reset lands on the beat-1 edge of a misaligned store.
        n0 = nrsp;
        req_valid = 1; req_we = 1; req_func = F_WORD; req_addr = 32'h31; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("ready_post_rst", 32'(req_ready), 32'h1);
        repeat (3) @(posedge clk); #1;
        chk("no_rsp_after_rst", 32'(nrsp - n0), 32'h0);
        t_chk("ld_w30", 0, 0, F_WORD, 32'h30, 32'h0, 32'hBBCCDD00, 0, 1);
        t_chk("ld_w34", 0, 0, F_WORD, 32'h34, 32'h0, 32'h00000000, 0, 1);

        stream(1, 32'h40, 8, 32'h5A000000);
        repeat (2) @(posedge clk); #1;
        n0 = nrsp;
        stream(0, 32'h40, 8, 32'h0);
        repeat (3) @(posedge clk); #1;
        chk("b2b_count", 32'(nrsp - n0), 32'h8);
        chk("b2b_last", last_rd, 32'h5A000007);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
